// File: rtl/avg_pix_stream_if.sv
// Pixel stream bundle: accepted input pixels in, one unthrottled filtered pixel stream out.
interface avg_pix_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;
    logic             out_eof;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, out_valid, out_data, out_eof
    );
    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, out_valid, out_data, out_eof
    );
endinterface

// File: rtl/avg_pix_stream.sv
// Streaming 3x3 neighbour averager: two line buffers plus window in one tap chain,
// edge pixels pass through, interior pixels bypass/blend/mean per the frame's mode.
module avg_pix_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    avg_pix_stream_if.slave bus
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int TAPS  = 2 * IMG_W + 3;
    localparam int CNT_W = $clog2(NPIX + IMG_W + 2);
    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int FL_W  = $clog2(IMG_W + 2);
    localparam int SUM_W = PIX_W + 3;
    localparam int BL_W  = PIX_W + 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic             in_ready_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] adv_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic [COL_W-1:0] c_col;
    logic [ROW_W-1:0] c_row;
    logic [PIX_W-1:0] taps [TAPS];

    logic             start;
    logic             accept;
    logic             adv;
    logic             ctr_hit;
    logic [PIX_W-1:0] new_pix;

    logic             vld_p0, edge_p0, eof_p0;
    logic [1:0]       mode_p0;
    logic             vld_p1, edge_p1, eof_p1;
    logic [1:0]       mode_p1;
    logic [PIX_W-1:0] win_p1 [9];
    logic [SUM_W-1:0] sum_p1;
    logic [PIX_W-1:0] res_p1;
    logic             vld_p2, eof_p2;
    logic [PIX_W-1:0] data_p2;

    function automatic logic [PIX_W-1:0] blend_pix(input logic [PIX_W-1:0] orig,
                                                   input logic [SUM_W-1:0] s);
        logic [BL_W-1:0] acc;
        acc = BL_W'({orig, 3'b000}) + BL_W'(s);
        return acc[BL_W-1:4];
    endfunction

    function automatic logic [PIX_W-1:0] mean_pix(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:3];
    endfunction

    // One advance per accepted pixel or per flush cycle; flush injects zeros.
    assign start   = (state == IDLE) && bus.in_valid && bus.in_sof;
    assign accept  = (state == RUN) && bus.in_valid;
    assign adv     = start || accept || (state == FLUSH);
    assign new_pix = (state == FLUSH) ? '0 : bus.in_data;
    assign ctr_hit = adv && (adv_cnt >= CNT_W'(IMG_W + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_r <= 1'b1;
            mode_r     <= '0;
            adv_cnt    <= '0;
            fl_cnt     <= '0;
        end else begin
            if (adv)
                adv_cnt <= adv_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        mode_r <= (mode == 2'd3) ? 2'd0 : mode;
                    end
                end
                RUN: begin
                    if (accept && adv_cnt == CNT_W'(NPIX - 1)) begin
                        state      <= FLUSH;
                        in_ready_r <= 1'b0;
                        fl_cnt     <= '0;
                    end
                end
                FLUSH: begin
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == FL_W'(IMG_W)) begin
                        state      <= IDLE;
                        in_ready_r <= 1'b1;
                        adv_cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tap i holds the pixel advanced i steps ago; centre sits at IMG_W+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++)
                taps[i] <= '0;
        end else if (adv) begin
            taps[0] <= new_pix;
            for (int i = 1; i < TAPS; i++)
                taps[i] <= taps[i-1];
        end
    end

    // Stage 0: position of the centre completed by this advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            edge_p0 <= 1'b0;
            eof_p0  <= 1'b0;
            mode_p0 <= '0;
            c_col   <= '0;
            c_row   <= '0;
        end else begin
            vld_p0  <= ctr_hit;
            edge_p0 <= (c_row == '0) || (c_row == ROW_W'(IMG_H - 1)) ||
                       (c_col == '0) || (c_col == COL_W'(IMG_W - 1));
            eof_p0  <= (c_row == ROW_W'(IMG_H - 1)) && (c_col == COL_W'(IMG_W - 1));
            mode_p0 <= mode_r;
            if (start) begin
                c_col <= '0;
                c_row <= '0;
            end else if (ctr_hit) begin
                if (c_col == COL_W'(IMG_W - 1)) begin
                    c_col <= '0;
                    c_row <= c_row + 1'b1;
                end else begin
                    c_col <= c_col + 1'b1;
                end
            end
        end
    end

    // Stage 1: register the 3x3 window.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        edge_p1   <= edge_p0;
        eof_p1    <= eof_p0;
        mode_p1   <= mode_p0;
        win_p1[0] <= taps[2*IMG_W+2];
        win_p1[1] <= taps[2*IMG_W+1];
        win_p1[2] <= taps[2*IMG_W];
        win_p1[3] <= taps[IMG_W+2];
        win_p1[4] <= taps[IMG_W+1];
        win_p1[5] <= taps[IMG_W];
        win_p1[6] <= taps[2];
        win_p1[7] <= taps[1];
        win_p1[8] <= taps[0];
    end

    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < 9; i++)
            if (i != 4)
                sum_p1 = sum_p1 + SUM_W'(win_p1[i]);
    end

    always_comb begin
        res_p1 = win_p1[4];
        if (!edge_p1) begin
            case (mode_p1)
                2'd1:    res_p1 = blend_pix(win_p1[4], sum_p1);
                2'd2:    res_p1 = mean_pix(sum_p1);
                default: res_p1 = win_p1[4];
            endcase
        end
    end

    // Stage 2: register the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            eof_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            eof_p2 <= vld_p1 && eof_p1;
            if (vld_p1)
                data_p2 <= res_p1;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;
    assign bus.out_eof   = eof_p2;

endmodule

// File: tb/tb_avg_pix_stream.sv
// Directed bench for avg_pix_stream on a 4x3 frame with a small reference model.
module tb_avg_pix_stream;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode;

    avg_pix_stream_if #(.PIX_W(PIX_W)) bus ();

    avg_pix_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q_data [$];
    logic       q_eof  [$];
    int         q_cyc  [$];

    always @(negedge clk) begin
        if (bus.out_valid) begin
            q_data.push_back(bus.out_data);
            q_eof.push_back(bus.out_eof);
            q_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] fr [NPIX];
    int         adv_edge [NPIX + IMG_W + 1];

    function automatic logic [7:0] ref_pix(input int k, input int md);
        int r, c, s;
        r = k / IMG_W;
        c = k % IMG_W;
        if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1 || md == 0 || md == 3)
            return fr[k];
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0)
                    s += int'(fr[(r + dr) * IMG_W + c + dc]);
        if (md == 1)
            return 8'((8 * int'(fr[k]) + s) / 16);
        return 8'(s / 8);
    endfunction

    task automatic send_pix(input string name, input int k, input int md);
        int w;
        bus.in_valid = 1'b1;
        bus.in_sof   = (k == 0);
        bus.in_data  = fr[k];
        mode         = 2'(md);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check($sformatf("%s_ready_timeout", name), 32'd0, 32'd1);
        @(posedge clk); #1;
        adv_edge[k]  = cyc;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic run_frame(input string name, input int md0, input int md1,
                             input int bub_at, input int nbub);
        int low_n, w, n;
        q_data.delete(); q_eof.delete(); q_cyc.delete();
        for (int k = 0; k < NPIX; k++) begin
            send_pix(name, k, (k == 0) ? md0 : md1);
            if (k == bub_at)
                repeat (nbub) begin @(posedge clk); #1; end
        end
        low_n = 0;
        while (!bus.in_ready && low_n < 20) begin
            low_n++;
            @(posedge clk); #1;
        end
        check($sformatf("%s_flush_len", name), low_n, IMG_W + 1);
        for (int i = 0; i <= IMG_W; i++)
            adv_edge[NPIX + i] = adv_edge[NPIX - 1] + 1 + i;
        w = 0;
        while (q_data.size() < NPIX && w < 40) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        check($sformatf("%s_count", name), q_data.size(), NPIX);
        n = (q_data.size() < NPIX) ? q_data.size() : NPIX;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_data%0d", name, k), q_data[k], ref_pix(k, md0));
            check($sformatf("%s_eof%0d", name, k), q_eof[k], (k == NPIX - 1));
            check($sformatf("%s_time%0d", name, k), q_cyc[k], adv_edge[k + IMG_W + 1] + 2);
        end
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        mode         = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_eof", bus.out_eof, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < NPIX; k++) fr[k] = 8'h00;
        run_frame("zero_m1", 1, 1, -1, 0);

        for (int k = 0; k < NPIX; k++) fr[k] = 8'h00;
        fr[5] = 8'hFF;
        run_frame("imp_m1", 1, 1, -1, 0);
        if (q_data.size() == NPIX) begin
            check("imp_m1_c11", q_data[5], 8'h7F);
            check("imp_m1_c12", q_data[6], 8'h0F);
            check("imp_m1_edge10", q_data[4], 8'h00);
        end
        run_frame("imp_m2", 2, 2, -1, 0);
        if (q_data.size() == NPIX) begin
            check("imp_m2_c11", q_data[5], 8'h00);
            check("imp_m2_c12", q_data[6], 8'h1F);
        end

        for (int k = 0; k < NPIX; k++) fr[k] = 8'hFF;
        run_frame("ff_m1", 1, 1, -1, 0);
        if (q_data.size() == NPIX) check("ff_m1_c11", q_data[5], 8'hFF);
        run_frame("ff_m2", 2, 2, -1, 0);
        if (q_data.size() == NPIX) check("ff_m2_c12", q_data[6], 8'hFF);

        for (int k = 0; k < NPIX; k++) fr[k] = 8'(k);
        run_frame("ramp_m0", 0, 0, -1, 0);
        if (q_data.size() == NPIX) check("ramp_m0_c12", q_data[6], 8'h06);

        for (int k = 0; k < NPIX; k++) fr[k] = 8'(k * 16 + 3);
        run_frame("stall_m2", 2, 2, 6, 3);
        if (q_data.size() == NPIX) check("stall_gap", q_cyc[2] - q_cyc[1], 4);

        for (int k = 0; k < NPIX; k++) fr[k] = 8'((k * 37 + 11) % 256);
        run_frame("toggle_m1", 1, 2, -1, 0);

        q_data.delete(); q_eof.delete(); q_cyc.delete();
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("idle_nosof_outs", q_data.size(), 0);
        check("idle_nosof_ready", bus.in_ready, 1);
        for (int k = 0; k < NPIX; k++) fr[k] = 8'(8'hA0 + k);
        run_frame("after_idle_m3", 3, 3, -1, 0);

        for (int k = 0; k < NPIX; k++) fr[k] = 8'(k * 20);
        q_data.delete(); q_eof.delete(); q_cyc.delete();
        for (int k = 0; k < 8; k++) send_pix("rst_mid", k, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_data.delete(); q_eof.delete(); q_cyc.delete();
        @(negedge clk);
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_ready", bus.in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_outs", q_data.size(), 0);
        for (int k = 0; k < NPIX; k++) fr[k] = 8'h00;
        fr[5] = 8'hFF;
        run_frame("post_rst_m1", 1, 1, -1, 0);
        if (q_data.size() == NPIX) check("post_rst_c11", q_data[5], 8'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avg_pix_stream.md
Name: avg_pix_stream

Overview:
- Streaming, parametrised successor to the combinational 8-neighbour pixel averager.
- Accepts one raster-order frame of single-channel pixels and holds two line buffers plus a 3x3 window.
- Emits one filtered pixel per input pixel, in raster order, with a selectable blend mode.
- Sits between the pixel source (capture/decoder) and the frame writer; handles frame start, edge pixels and end-of-frame flush internally.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
mode  input  2  0=bypass, 1=blend, 2=neighbour mean, 3=reserved (treated as 0); sampled on the frame's first accepted pixel
in_valid  input  1  input pixel valid
in_sof  input  1  marks first pixel of a frame; qualified by in_valid
in_data  input  PIX_W  input pixel
in_ready  output  1  block accepts a pixel when in_valid&&in_ready
out_valid  output  1  output pixel valid, single-cycle pulse per pixel; no backpressure
out_data  output  PIX_W  filtered pixel
out_eof  output  1  high with out_valid on the frame's last output pixel

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0, out_data=0, out_eof=0; counters, window and mode register cleared. Reset mid-frame discards the partial frame. No output is produced for pixels accepted before reset.
- FSM IDLE -> RUN: on in_valid&&in_sof. That pixel is accepted as index 0, and mode is latched. In IDLE, in_valid without in_sof is accepted and dropped.
- RUN: in_ready=1. Each accept shifts the line buffers and window and increments the pixel index k. in_sof in RUN is treated as ordinary data. Bubbles (in_valid=0) stall the pipeline and nothing advances.
- RUN -> FLUSH: on the accept of index IMG_W*IMG_H-1.
- FLUSH: in_ready=0 for exactly IMG_W+1 cycles. Each cycle injects one internal dummy pixel (value 0, never used by a valid window centre) to drain the pipeline.
- FLUSH -> IDLE: after the last dummy cycle. in_ready returns to 1 the following cycle.
- Output timing: the output for centre index k is triggered by the advance (accept or flush cycle) of index k+IMG_W+1. out_valid asserts exactly 2 cycles after that advance: stage 1 registers the window, stage 2 registers the result.
- Output count: exactly IMG_W*IMG_H outputs per frame, in raster order. out_eof accompanies the last one.
- Edge pixels (row 0, row IMG_H-1, column 0, column IMG_W-1): out_data = orig in every mode. Window neighbours never wrap across lines or frames.
- Interior pixels, with S = sum of 8 neighbours in a PIX_W+3-bit accumulator (no overflow):
  - mode 0: out = orig
  - mode 1: out = (8*orig + S) >> 4; truncating, PIX_W+4-bit intermediate
  - mode 2: out = S >> 3; truncating
  - Results never exceed 2^PIX_W-1. No saturation logic is needed.
- A new frame's in_sof is accepted only in IDLE, so back-to-back frames see the in_ready gap of the flush.

Test Plan:
(All with PIX_W=8, IMG_W=4, IMG_H=3.)
- All-zero frame, mode 1 -> 12 outputs, all 0x00; out_eof only on the 12th; in_ready low exactly 5 cycles after the 12th accept.
- Impulse 0xFF at (1,1), others 0, mode 1 -> out(1,1)=0x7F, out(1,2)=0x0F, all edge outputs 0x00. Same frame in mode 2 -> out(1,1)=0x00, out(1,2)=0x1F.
- Uniform 0xFF frame in modes 1 and 2 -> all outputs 0xFF (checks the width of the max-sum path). Mode 0 with a ramp 0x00..0x0B -> outputs equal inputs in order.
- Latency/stall: continuous input -> first out_valid 2 cycles after accepting index 5. Insert 3 bubble cycles after index 6 -> subsequent outputs delayed by 3, values unchanged.
- Mode toggled 1->2 mid-frame -> whole frame still uses mode 1. in_valid without in_sof in IDLE -> no outputs, FSM stays IDLE.
- rst pulsed after index 7 -> next cycle out_valid=0 and in_ready=1. A fresh frame then produces correct outputs with no stale neighbours.
